// File: rtl/thresholding_loader_pkg.sv
// Shared types and helpers for the thresholding AXI-Lite loader.
// State encoding, AXI response codes and the threshold address packer.
package thresholding_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_BWAIT,
        S_RDBACK,
        S_RWAIT,
        S_DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Byte address {cf, pe, t, 2'b00}; a zero-width pe field collapses cleanly.
    function automatic logic [31:0] pack_addr(
        input logic [31:0] cf,
        input logic [31:0] pe,
        input logic [31:0] t,
        input int          pe_w,
        input int          t_w
    );
        return (cf << (pe_w + t_w + 2)) | (pe << (t_w + 2)) | (t << 2);
    endfunction

endpackage

// File: rtl/thresholding_loader_addr_cnt.sv
// Nested t/pe/cf word counter for the threshold loader; flags the final word
// and presents the packed AXI-Lite byte address of the current word.
module thresholding_loader_addr_cnt
    import thresholding_loader_pkg::*;
#(
    parameter int N         = 4,
    parameter int PE        = 2,
    parameter int CF        = 3,
    parameter int ADDR_BITS = 9
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    input  logic                 i_inc,
    output logic                 o_last,
    output logic [ADDR_BITS-1:0] o_addr
);

    localparam int PE_W = (PE > 1) ? $clog2(PE) : 1;
    localparam int CF_W = (CF > 1) ? $clog2(CF) : 1;
    localparam int PE_F = $clog2(PE);

    localparam logic [N-1:0]    T_MAX  = N'(2**N - 2);
    localparam logic [PE_W-1:0] PE_MAX = PE_W'(PE - 1);
    localparam logic [CF_W-1:0] CF_MAX = CF_W'(CF - 1);

    logic [N-1:0]    r_t;
    logic [PE_W-1:0] r_pe;
    logic [CF_W-1:0] r_cf;
    logic            w_t_wrap;
    logic            w_pe_wrap;
    logic            w_cf_wrap;

    assign w_t_wrap  = (r_t == T_MAX);
    assign w_pe_wrap = (r_pe == PE_MAX);
    assign w_cf_wrap = (r_cf == CF_MAX);

    // NOTE: state updates use <= so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_t  <= '0;
            r_pe <= '0;
            r_cf <= '0;
        end else if (i_inc) begin
            if (w_t_wrap) begin
                r_t <= '0;
                if (w_pe_wrap) begin
                    r_pe <= '0;
                    r_cf <= w_cf_wrap ? '0 : r_cf + 1'b1;
                end else begin
                    r_pe <= r_pe + 1'b1;
                end
            end else begin
                r_t <= r_t + 1'b1;
            end
        end
    end

    assign o_last = w_t_wrap && w_pe_wrap && w_cf_wrap;
    assign o_addr = ADDR_BITS'(pack_addr(32'(r_cf), 32'(r_pe), 32'(r_t), PE_F, N));

endmodule

// File: rtl/thresholding_axilite_loader.sv
// Streams threshold words into a thresholding core over AXI-Lite, one write per word.
// Define THRESHOLDING_LOADER_READBACK_EN to verify each word with a read-back.
module thresholding_axilite_loader
    import thresholding_loader_pkg::*;
#(
    parameter int N      = 4,
    parameter int K      = 9,
    parameter int C      = 6,
    parameter int PE     = 2,
    parameter int SIGNED = 1,
    localparam int CF        = C / PE,
    localparam int ADDR_BITS = $clog2(CF) + $clog2(PE) + N + 2,
    localparam int TW        = ((K + 7) / 8) * 8
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tvalid,
    input  logic [TW-1:0]        s_axis_tdata,
    output logic                 m_axilite_AWVALID,
    input  logic                 m_axilite_AWREADY,
    output logic [ADDR_BITS-1:0] m_axilite_AWADDR,
    output logic                 m_axilite_WVALID,
    input  logic                 m_axilite_WREADY,
    output logic [31:0]          m_axilite_WDATA,
    output logic [3:0]           m_axilite_WSTRB,
    input  logic                 m_axilite_BVALID,
    output logic                 m_axilite_BREADY,
    input  logic [1:0]           m_axilite_BRESP,
    output logic                 m_axilite_ARVALID,
    input  logic                 m_axilite_ARREADY,
    output logic [ADDR_BITS-1:0] m_axilite_ARADDR,
    input  logic                 m_axilite_RVALID,
    output logic                 m_axilite_RREADY,
    input  logic [31:0]          m_axilite_RDATA,
    input  logic [1:0]           m_axilite_RRESP
);

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_aw_done;
    logic                   r_w_done;
    logic                   r_error;
    logic                   r_last;
    logic [K-1:0]           r_data;
    logic [ADDR_BITS-1:0]   r_addr;
    logic                   w_cnt_last;
    logic [ADDR_BITS-1:0]   w_cnt_addr;
    logic                   w_clr;
    logic                   w_fetch_hs;
    logic                   w_unused;

    assign w_clr      = (r_state == S_IDLE) && start;
    assign w_fetch_hs = (r_state == S_FETCH) && s_axis_tvalid;

    thresholding_loader_addr_cnt #(
        .N         (N),
        .PE        (PE),
        .CF        (CF),
        .ADDR_BITS (ADDR_BITS)
    ) u_addr_cnt (
        .i_clk  (ap_clk),
        .i_rst  (ap_rst),
        .i_clr  (w_clr),
        .i_inc  (w_fetch_hs),
        .o_last (w_cnt_last),
        .o_addr (w_cnt_addr)
    );

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        w_next            = r_state;
        busy              = 1'b1;
        done              = 1'b0;
        s_axis_tready     = 1'b0;
        m_axilite_AWVALID = 1'b0;
        m_axilite_WVALID  = 1'b0;
        m_axilite_BREADY  = 1'b0;
        m_axilite_ARVALID = 1'b0;
        m_axilite_RREADY  = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                m_axilite_AWVALID = !r_aw_done;
                m_axilite_WVALID  = !r_w_done;
                if ((r_aw_done || m_axilite_AWREADY) && (r_w_done || m_axilite_WREADY))
                    w_next = S_BWAIT;
            end
            S_BWAIT: begin
                m_axilite_BREADY = 1'b1;
`ifdef THRESHOLDING_LOADER_READBACK_EN
                if (m_axilite_BVALID) w_next = S_RDBACK;
`else
                if (m_axilite_BVALID) w_next = r_last ? S_DONE : S_FETCH;
`endif
            end
`ifdef THRESHOLDING_LOADER_READBACK_EN
            S_RDBACK: begin
                m_axilite_ARVALID = 1'b1;
                if (m_axilite_ARREADY) w_next = S_RWAIT;
            end
            S_RWAIT: begin
                m_axilite_RREADY = 1'b1;
                if (m_axilite_RVALID) w_next = r_last ? S_DONE : S_FETCH;
            end
`endif
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state   <= S_IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_error   <= 1'b0;
            r_last    <= 1'b0;
            r_data    <= '0;
            r_addr    <= '0;
        end else begin
            r_state <= w_next;
            if (w_clr) r_error <= 1'b0;
            // Word and address are frozen here so both stay stable for the whole transaction.
            if (w_fetch_hs) begin
                r_data    <= s_axis_tdata[K-1:0];
                r_addr    <= w_cnt_addr;
                r_last    <= w_cnt_last;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (m_axilite_AWVALID && m_axilite_AWREADY) r_aw_done <= 1'b1;
            if (m_axilite_WVALID && m_axilite_WREADY)   r_w_done  <= 1'b1;
            if (m_axilite_BREADY && m_axilite_BVALID && (m_axilite_BRESP != RESP_OKAY))
                r_error <= 1'b1;
`ifdef THRESHOLDING_LOADER_READBACK_EN
            if (m_axilite_RREADY && m_axilite_RVALID &&
                ((m_axilite_RRESP != RESP_OKAY) || (m_axilite_RDATA[K-1:0] != r_data)))
                r_error <= 1'b1;
`endif
        end
    end

    assign error            = r_error;
    assign m_axilite_AWADDR = r_addr;
    assign m_axilite_WSTRB  = 4'hF;
    assign m_axilite_WDATA  = (SIGNED != 0) ? {{(32-K){r_data[K-1]}}, r_data}
                                            : {{(32-K){1'b0}}, r_data};
`ifdef THRESHOLDING_LOADER_READBACK_EN
    assign m_axilite_ARADDR = r_addr;
`else
    assign m_axilite_ARADDR = '0;
`endif

    // Upper tdata bits and, without read-back, the whole R channel are don't-care.
    assign w_unused = &{1'b0, s_axis_tdata, m_axilite_ARREADY, m_axilite_RVALID,
                        m_axilite_RDATA, m_axilite_RRESP};

endmodule

// File: tb/tb_thresholding_axilite_loader.sv
// Directed bench for thresholding_axilite_loader (N=2, C=4, PE=2, K=9) with a
// behavioural AXI-Lite responder and stream source; a SIGNED=0 twin checks extension.
module tb_thresholding_axilite_loader;

    localparam int N = 2, K = 9, C = 4, PE = 2, AB = 6, TW = 16, WORDS = 12;
`ifdef THRESHOLDING_LOADER_READBACK_EN
    localparam int PER = 5;
`else
    localparam int PER = 3;
`endif
    localparam logic [AB-1:0] EXP_ADDR [WORDS] = '{6'h00, 6'h04, 6'h08, 6'h10, 6'h14, 6'h18,
                                                   6'h20, 6'h24, 6'h28, 6'h30, 6'h34, 6'h38};

    logic ap_clk = 1'b0, ap_rst = 1'b1, start = 1'b0;
    logic tvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic arready = 1'b0, rvalid = 1'b0;
    logic [TW-1:0] tdata = '0;
    logic [1:0] bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = '0;

    logic busy, done, error, tready, awvalid, wvalid, bready, arvalid, rready;
    logic [AB-1:0] awaddr, araddr;
    logic [31:0] wdata;
    logic [3:0] wstrb;
    logic u_busy, u_done, u_error, u_tready, u_awvalid, u_wvalid, u_bready, u_arvalid, u_rready;
    logic [AB-1:0] u_awaddr, u_araddr;
    logic [31:0] u_wdata;
    logic [3:0] u_wstrb;

    always #5 ap_clk = ~ap_clk;

    thresholding_axilite_loader #(.N(N), .K(K), .C(C), .PE(PE), .SIGNED(1)) u_dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start), .busy(busy), .done(done), .error(error),
        .s_axis_tready(tready), .s_axis_tvalid(tvalid), .s_axis_tdata(tdata),
        .m_axilite_AWVALID(awvalid), .m_axilite_AWREADY(awready), .m_axilite_AWADDR(awaddr),
        .m_axilite_WVALID(wvalid), .m_axilite_WREADY(wready), .m_axilite_WDATA(wdata),
        .m_axilite_WSTRB(wstrb), .m_axilite_BVALID(bvalid), .m_axilite_BREADY(bready),
        .m_axilite_BRESP(bresp), .m_axilite_ARVALID(arvalid), .m_axilite_ARREADY(arready),
        .m_axilite_ARADDR(araddr), .m_axilite_RVALID(rvalid), .m_axilite_RREADY(rready),
        .m_axilite_RDATA(rdata), .m_axilite_RRESP(rresp)
    );

    thresholding_axilite_loader #(.N(N), .K(K), .C(C), .PE(PE), .SIGNED(0)) u_dut_u (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start), .busy(u_busy), .done(u_done),
        .error(u_error), .s_axis_tready(u_tready), .s_axis_tvalid(tvalid), .s_axis_tdata(tdata),
        .m_axilite_AWVALID(u_awvalid), .m_axilite_AWREADY(awready), .m_axilite_AWADDR(u_awaddr),
        .m_axilite_WVALID(u_wvalid), .m_axilite_WREADY(wready), .m_axilite_WDATA(u_wdata),
        .m_axilite_WSTRB(u_wstrb), .m_axilite_BVALID(bvalid), .m_axilite_BREADY(u_bready),
        .m_axilite_BRESP(bresp), .m_axilite_ARVALID(u_arvalid), .m_axilite_ARREADY(arready),
        .m_axilite_ARADDR(u_araddr), .m_axilite_RVALID(rvalid), .m_axilite_RREADY(u_rready),
        .m_axilite_RDATA(rdata), .m_axilite_RRESP(rresp)
    );

    int n_vec = 0, n_err = 0;

    // Responder configuration and transaction log
    int aw_delay = 0, bresp_err_word = -1, rd_corrupt_word = -1;
    int stream_len = 0, stream_idx = 0;
    logic [TW-1:0] stream_vals [WORDS];
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, done_cnt = 0;
    int aw_wait = 0;
    bit aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0, strb_bad = 0;
    logic [AB-1:0] wr_addr [16], ar_addr [16], aw_hold, last_ar;
    logic [31:0] wr_data [16], wr_data_u [16], mem [16];
    int aw_cyc [16], w_cyc [16];
    bit aw_unstable [16];
    logic err_at_b [16];

    initial begin
        forever begin
            @(negedge ap_clk);
            if (ap_rst) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; tvalid = 0;
                aw_wait = 0; aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            end else begin
                if (done) done_cnt++;
                if (stream_idx < stream_len) begin
                    tvalid = 1'b1;
                    tdata  = stream_vals[stream_idx];
                end else begin
                    tvalid = 1'b0;
                end
                if (tvalid && tready) stream_idx++;
                bvalid = b_pend;
                bresp  = (b_cnt == bresp_err_word) ? 2'b10 : 2'b00;
                if (bvalid && bready) begin
                    err_at_b[b_cnt] = error;
                    b_cnt++;
                    b_pend = 0;
                end
                rvalid = r_pend;
                rresp  = 2'b00;
                rdata  = mem[last_ar >> 2] ^ ((r_cnt == rd_corrupt_word) ? 32'h1 : 32'h0);
                if (rvalid && rready) begin
                    r_cnt++;
                    r_pend = 0;
                end
                arready = arvalid;
                if (arvalid) begin
                    ar_addr[ar_cnt] = araddr;
                    last_ar = araddr;
                    ar_cnt++;
                    r_pend = 1;
                end
                if (awvalid) begin
                    if (aw_cyc[aw_cnt] == 0) aw_hold = awaddr;
                    else if (awaddr !== aw_hold) aw_unstable[aw_cnt] = 1;
                    aw_cyc[aw_cnt]++;
                    awready = (aw_wait >= aw_delay);
                    aw_wait++;
                    if (awready) begin
                        wr_addr[aw_cnt] = awaddr;
                        aw_cnt++;
                        aw_got = 1;
                        aw_wait = 0;
                    end
                end else begin
                    awready = 0;
                    aw_wait = 0;
                end
                wready = wvalid;
                if (wvalid) begin
                    w_cyc[w_cnt]++;
                    wr_data[w_cnt]   = wdata;
                    wr_data_u[w_cnt] = u_wdata;
                    if (wstrb !== 4'hF) strb_bad = 1;
                    w_cnt++;
                    w_got = 1;
                end
                if (aw_got && w_got) begin
                    b_pend = 1;
                    aw_got = 0;
                    w_got = 0;
                    mem[wr_addr[aw_cnt-1] >> 2] = wr_data[w_cnt-1];
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge ap_clk);
        #1;
    endtask

    task automatic clear_log();
        aw_delay = 0; bresp_err_word = -1; rd_corrupt_word = -1;
        stream_len = 0; stream_idx = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; done_cnt = 0; strb_bad = 0;
        for (int i = 0; i < 16; i++) begin
            aw_cyc[i] = 0; w_cyc[i] = 0; aw_unstable[i] = 0; err_at_b[i] = 1'bx;
            wr_addr[i] = 'x; ar_addr[i] = 'x; wr_data[i] = 'x; wr_data_u[i] = 'x;
        end
    endtask

    task automatic load_seq();
        for (int i = 0; i < WORDS; i++) stream_vals[i] = TW'(i + 1);
        stream_len = WORDS;
    endtask

    task automatic run_load(output int cyc, output bit timed_out, output logic busy1,
                            output logic err1);
        start = 1'b1;
        tick();
        start = 1'b0;
        busy1 = busy;
        err1  = error;
        cyc   = 1;
        while (done !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        timed_out = (done !== 1'b1);
        tick();
        tick();
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        repeat (3) tick();
        n_vec++;
        if ({tready, awvalid, wvalid, bready, arvalid, rready, busy, done, error} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 000000000",
                     {tready, awvalid, wvalid, bready, arvalid, rready, busy, done, error});
        end
        n_vec++;
        if (araddr !== '0) begin
            n_err++;
            $display("FAIL reset_araddr: got %h expected 00", araddr);
        end
        ap_rst = 1'b0;
        clear_log();
        load_seq();
        repeat (4) tick();
        n_vec++;
        if (stream_idx !== 0 || tready !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_consume: consumed %0d tready %b expected 0 0", stream_idx, tready);
        end
    endtask

    task automatic test_basic();
        int cyc; bit to; logic b1, e1;
        clear_log();
        load_seq();
        run_load(cyc, to, b1, e1);
        n_vec++;
        if (to || cyc != WORDS * PER + 1) begin
            n_err++;
            $display("FAIL basic_latency: got %0d cycles (timeout %0b) expected %0d", cyc, to, WORDS * PER + 1);
        end
        n_vec++;
        if (b1 !== 1'b1) begin n_err++; $display("FAIL basic_busy_after_start: got %b expected 1", b1); end
        n_vec++;
        if (aw_cnt != WORDS || w_cnt != WORDS || b_cnt != WORDS) begin
            n_err++;
            $display("FAIL basic_counts: aw %0d w %0d b %0d expected 12 each", aw_cnt, w_cnt, b_cnt);
        end
        for (int i = 0; i < WORDS; i++) begin
            n_vec++;
            if (wr_addr[i] !== EXP_ADDR[i] || wr_data[i] !== 32'(i + 1)) begin
                n_err++;
                $display("FAIL basic_word%0d: addr %h data %h expected %h %h",
                         i, wr_addr[i], wr_data[i], EXP_ADDR[i], 32'(i + 1));
            end
        end
        n_vec++;
        if (done_cnt != 1 || error !== 1'b0 || busy !== 1'b0 || strb_bad) begin
            n_err++;
            $display("FAIL basic_end: done_pulses %0d error %b busy %b strb_bad %0b expected 1 0 0 0",
                     done_cnt, error, busy, strb_bad);
        end
`ifdef THRESHOLDING_LOADER_READBACK_EN
        n_vec++;
        if (ar_cnt != WORDS || r_cnt != WORDS) begin
            n_err++;
            $display("FAIL basic_reads: ar %0d r %0d expected 12 12", ar_cnt, r_cnt);
        end
`else
        n_vec++;
        if (ar_cnt != 0) begin
            n_err++;
            $display("FAIL no_readback: ar handshakes %0d expected 0", ar_cnt);
        end
`endif
    endtask

    task automatic test_extend();
        int cyc; bit to; logic b1, e1;
        logic [31:0] exp_s [4];
        logic [31:0] exp_u [4];
        exp_s = '{32'hFFFF_FFFF, 32'hFFFF_FF00, 32'h0000_00FF, 32'h0000_0001};
        exp_u = '{32'h0000_01FF, 32'h0000_0100, 32'h0000_00FF, 32'h0000_0001};
        clear_log();
        for (int i = 0; i < WORDS; i++) stream_vals[i] = '0;
        stream_vals[0] = 16'h01FF; stream_vals[1] = 16'h0100;
        stream_vals[2] = 16'h00FF; stream_vals[3] = 16'hFE01;
        stream_len = WORDS;
        run_load(cyc, to, b1, e1);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (wr_data[i] !== exp_s[i] || wr_data_u[i] !== exp_u[i]) begin
                n_err++;
                $display("FAIL extend_word%0d: signed %h unsigned %h expected %h %h",
                         i, wr_data[i], wr_data_u[i], exp_s[i], exp_u[i]);
            end
        end
    endtask

    task automatic test_aw_delay();
        int cyc; bit to; logic b1, e1;
        clear_log();
        aw_delay = 3;
        load_seq();
        run_load(cyc, to, b1, e1);
        n_vec++;
        if (aw_cyc[0] != 4 || w_cyc[0] != 1 || aw_unstable[0] || wr_addr[0] !== 6'h00) begin
            n_err++;
            $display("FAIL awdelay_word0: aw_cycles %0d w_cycles %0d unstable %0b addr %h expected 4 1 0 00",
                     aw_cyc[0], w_cyc[0], aw_unstable[0], wr_addr[0]);
        end
        n_vec++;
        if (to || cyc != WORDS * (PER + 3) + 1 || b_cnt != WORDS || wr_addr[11] !== 6'h38) begin
            n_err++;
            $display("FAIL awdelay_load: cycles %0d b %0d last_addr %h expected %0d 12 38",
                     cyc, b_cnt, wr_addr[11], WORDS * (PER + 3) + 1);
        end
    endtask

    task automatic test_bresp_err();
        int cyc; bit to; logic b1, e1;
        clear_log();
        bresp_err_word = 5;
        load_seq();
        run_load(cyc, to, b1, e1);
        n_vec++;
        if (err_at_b[5] !== 1'b0 || err_at_b[6] !== 1'b1 || err_at_b[11] !== 1'b1 || error !== 1'b1) begin
            n_err++;
            $display("FAIL bresp_sticky: at_b5 %b at_b6 %b at_b11 %b final %b expected 0 1 1 1",
                     err_at_b[5], err_at_b[6], err_at_b[11], error);
        end
        n_vec++;
        if (to || aw_cnt != WORDS || b_cnt != WORDS || done_cnt != 1) begin
            n_err++;
            $display("FAIL bresp_complete: aw %0d b %0d done %0d expected 12 12 1", aw_cnt, b_cnt, done_cnt);
        end
        clear_log();
        load_seq();
        run_load(cyc, to, b1, e1);
        n_vec++;
        if (e1 !== 1'b0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL bresp_clear_on_start: after_start %b final %b expected 0 0", e1, error);
        end
    endtask

`ifdef THRESHOLDING_LOADER_READBACK_EN
    task automatic test_readback();
        int cyc; bit to; logic b1, e1;
        clear_log();
        rd_corrupt_word = 3;
        load_seq();
        run_load(cyc, to, b1, e1);
        n_vec++;
        if (error !== 1'b1 || to) begin
            n_err++;
            $display("FAIL readback_error: got %b expected 1", error);
        end
        n_vec++;
        if (ar_addr[3] !== wr_addr[3] || ar_addr[3] !== 6'h10) begin
            n_err++;
            $display("FAIL readback_addr: araddr %h awaddr %h expected 10", ar_addr[3], wr_addr[3]);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int cyc; int guard; bit to; logic b1, e1;
        int aw_snap, w_snap, b_snap;
        clear_log();
        aw_delay = 10;
        load_seq();
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!(awvalid === 1'b1 && aw_cnt == 4) && guard < 300) begin
            tick();
            guard++;
        end
        n_vec++;
        if (guard >= 300) begin
            n_err++;
            $display("FAIL rstmid_reach_word4: timed out after %0d cycles", guard);
        end
        ap_rst = 1'b1;
        aw_snap = aw_cnt; w_snap = w_cnt; b_snap = b_cnt;
        tick();
        n_vec++;
        if ({awvalid, wvalid, bready, arvalid, rready, tready, busy} !== 7'b0) begin
            n_err++;
            $display("FAIL rstmid_valids: got %b expected 0000000",
                     {awvalid, wvalid, bready, arvalid, rready, tready, busy});
        end
        tick();
        ap_rst = 1'b0;
        tick();
        n_vec++;
        if (aw_cnt != aw_snap || w_cnt != w_snap || b_cnt != b_snap) begin
            n_err++;
            $display("FAIL rstmid_no_handshake: aw %0d w %0d b %0d expected %0d %0d %0d",
                     aw_cnt, w_cnt, b_cnt, aw_snap, w_snap, b_snap);
        end
        clear_log();
        load_seq();
        run_load(cyc, to, b1, e1);
        n_vec++;
        if (wr_addr[0] !== 6'h00 || wr_data[0] !== 32'h1 || aw_cnt != WORDS || done_cnt != 1 || to) begin
            n_err++;
            $display("FAIL rstmid_restart: addr0 %h data0 %h aw %0d done %0d expected 00 00000001 12 1",
                     wr_addr[0], wr_data[0], aw_cnt, done_cnt);
        end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_basic();
        test_extend();
        test_aw_delay();
        test_bresp_err();
`ifdef THRESHOLDING_LOADER_READBACK_EN
        test_readback();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
